// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cached-bus port between NUM_INPUTS requesters; optional watchdog via CBUS_ARB_TIMEOUT_EN.
// Latency: 1 IDLE cycle of arbitration before each grant; request/response paths are combinational while BUSY.
// Backpressure: oresp.ready is passed straight to the owner only; non-owners always see ready=0.

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;
endpackage

module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter  int NUM_INPUTS     = 2,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [NUM_INPUTS-1:0] req_vld;
    logic                  sel_vld;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W:0]        cand;
    logic [IDX_W-1:0]      owner_nxt;
    logic                  busy;
    logic                  own_vld;
    logic                  done;
    logic                  abort;
    logic                  tmo_hit;

    always_comb begin
        req_vld = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_vld[i] = ireqs[i].valid;
        end
    end

    // Walk from the farthest candidate back to rr_ptr so the closest valid one wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (req_vld[cand[IDX_W-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign own_vld   = req_vld[owner_q];
    assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
    assign done      = busy && own_vld && oresp.ready && oresp.last;
    assign abort     = busy && !own_vld;

`ifdef CBUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // The count holds the BUSY cycles already spent, so it trips on the last allowed one.
    always_comb begin
        tmo_cnt_d     = busy ? tmo_cnt_q + CNT_W'(1) : '0;
        tmo_hit       = busy && own_vld && !done && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        timeout_err_d = timeout_err_q | tmo_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    state_d = ST_BUSY;
                    owner_d = sel_idx;
                end
            end
            ST_BUSY: begin
                if (abort || done || tmo_hit) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_nxt;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs decode from the flopped state, so reset silences them asynchronously.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
            if (busy && (owner_q == IDX_W'(i))) begin
                iresps[i] = oresp;
                if (tmo_hit) begin
                    iresps[i].ready = 1'b0;
                end
            end
        end
        if (busy) begin
            oreq = ireqs[owner_q];
        end
    end

    assign grant_valid = busy;
    assign grant_idx   = owner_q;

endmodule
